// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, stage occupancy states, default width.
// Imported by the execute stage, its ALU core and the control unit's ALU decoder.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Valid/ready operation and result bundle of the ALU execute stage.
// Overflow exists only when ALU_EXEC_OVERFLOW_EN is defined.
interface alu_exec_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;
`ifdef ALU_EXEC_OVERFLOW_EN
    logic             Overflow;
`endif

    modport master (
        output in_valid,
        input  in_ready,
        output ALUControl,
        output SrcA,
        output SrcB,
        input  out_valid,
        output out_ready,
        input  ALUResult,
        input  Zero,
`ifdef ALU_EXEC_OVERFLOW_EN
        input  Overflow,
`endif
        input  Illegal
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  ALUControl,
        input  SrcA,
        input  SrcB,
        output out_valid,
        input  out_ready,
        output ALUResult,
        output Zero,
`ifdef ALU_EXEC_OVERFLOW_EN
        output Overflow,
`endif
        output Illegal
    );

endinterface

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: ADD/SUB/AND/OR/SLT with zero and illegal-code flags.
// Signed overflow output is built only with ALU_EXEC_OVERFLOW_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
`ifdef ALU_EXEC_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic             lt;

    assign sum  = a + b;
    assign diff = a - b;

    // SLT must correct the difference sign when the subtraction overflows
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt      = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_EXEC_OVERFLOW_EN
    logic add_ovf;

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        overflow = 1'b0;
        if (alu_control == ALU_ADD) begin
            overflow = add_ovf;
        end else if (alu_control == ALU_SUB) begin
            overflow = sub_ovf;
        end
    end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with a 2-entry skid buffer (main + skid).
// Optional Overflow output: define ALU_EXEC_OVERFLOW_EN.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_stage_if.slave bus
);

`ifdef ALU_EXEC_OVERFLOW_EN
    localparam int PW = WIDTH + 3;
`else
    localparam int PW = WIDTH + 2;
`endif

    logic [WIDTH-1:0] core_res;
    logic             core_zero;
    logic             core_ill;
    logic [PW-1:0]    core_pkt;

    logic [PW-1:0]    m_d;
    logic [PW-1:0]    m_q;
    logic [PW-1:0]    s_d;
    logic [PW-1:0]    s_q;
    occ_e             state_d;
    occ_e             state_q;

    logic             accept;
    logic             drain;

`ifdef ALU_EXEC_OVERFLOW_EN
    logic             core_ovf;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (bus.ALUControl),
        .a           (bus.SrcA),
        .b           (bus.SrcB),
        .result      (core_res),
        .zero        (core_zero),
        .illegal     (core_ill),
        .overflow    (core_ovf)
    );

    assign core_pkt     = {core_ovf, core_ill, core_zero, core_res};
    assign bus.Overflow = m_q[WIDTH+2];
`else
    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (bus.ALUControl),
        .a           (bus.SrcA),
        .b           (bus.SrcB),
        .result      (core_res),
        .zero        (core_zero),
        .illegal     (core_ill)
    );

    assign core_pkt = {core_ill, core_zero, core_res};
`endif

    // in_ready comes from registered occupancy only, never from out_ready
    assign bus.in_ready  = ~reset & (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.ALUResult = m_q[WIDTH-1:0];
    assign bus.Zero      = m_q[WIDTH];
    assign bus.Illegal   = m_q[WIDTH+1];

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_d     = core_pkt;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    m_d = core_pkt;
                end else if (accept) begin
                    s_d     = core_pkt;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed ops, backpressure, reset, random traffic
// compared against a 2-deep FIFO reference of plain-arithmetic ALU results.
module tb_alu_exec_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;
    exp_t q[$];

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_op(input logic [2:0] c,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        e  = '0;
        case (c)
            3'd0: begin
                r     = sa + sb;
                e.res = a + b;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd1: begin
                r     = sa - sb;
                e.res = a - b;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] ov;
        logic [31:0] ir;
        ov = {31'd0, bus.out_valid};
        ir = {31'd0, bus.in_ready};
        chk({tag, ".out_valid"}, ov, {31'd0, q.size() > 0});
        chk({tag, ".in_ready"}, ir, {31'd0, !reset && q.size() < 2});
        if (q.size() > 0) begin
            chk({tag, ".res"}, bus.ALUResult, q[0].res);
            chk({tag, ".zero"}, {31'd0, bus.Zero}, {31'd0, q[0].z});
            chk({tag, ".ill"}, {31'd0, bus.Illegal}, {31'd0, q[0].ill});
`ifdef ALU_EXEC_OVERFLOW_EN
            chk({tag, ".ovf"}, {31'd0, bus.Overflow}, {31'd0, q[0].ovf});
`endif
        end
    endtask

    task automatic cycle(input string tag);
        bit   acc;
        bit   otx;
        exp_t e;
        acc = bus.in_valid && q.size() < 2 && !reset;
        otx = q.size() > 0 && bus.out_ready;
        e   = ref_op(bus.ALUControl, bus.SrcA, bus.SrcB);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (otx) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        bus.in_valid   = v;
        bus.ALUControl = c;
        bus.SrcA       = a;
        bus.SrcB       = b;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        cycle("rst");
        reset = 1'b0;
        #1;
        chk("rst.in_ready_high", {31'd0, bus.in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.res", bus.ALUResult, 32'd0);
        chk("rst.zero", {31'd0, bus.Zero}, 32'd0);
        chk("rst.ill", {31'd0, bus.Illegal}, 32'd0);
`ifdef ALU_EXEC_OVERFLOW_EN
        chk("rst.ovf", {31'd0, bus.Overflow}, 32'd0);
`endif
    endtask

    task automatic op1(input string tag, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez,
                       input logic eill);
        drive(1'b1, c, a, b);
        bus.out_ready = 1'b1;
        cycle(tag);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".const_res"}, bus.ALUResult, er);
        chk({tag, ".const_z"}, {31'd0, bus.Zero}, {31'd0, ez});
        chk({tag, ".const_ill"}, {31'd0, bus.Illegal}, {31'd0, eill});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        nchk          = 0;
        nerr          = 0;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        do_reset();

        op1("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        op1("sub", ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        op1("and", ALU_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
        op1("or", ALU_OR, 32'hF000, 32'h000F, 32'hF00F, 1'b0, 1'b0);
        op1("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        op1("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,
            1'b1, 1'b0);
        op1("illegal", 3'b110, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
        op1("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
            1'b0, 1'b0);
`ifdef ALU_EXEC_OVERFLOW_EN
        chk("add_wrap.const_ovf", {31'd0, bus.Overflow}, 32'd1);
`endif
        op1("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef ALU_EXEC_OVERFLOW_EN
        chk("sub_wrap.const_ovf", {31'd0, bus.Overflow}, 32'd0);
`endif
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        cycle("drain");

        // backpressure: third op must wait until the stage drains
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 32'd1, 32'd0);
        cycle("bp1");
        drive(1'b1, ALU_ADD, 32'd2, 32'd0);
        cycle("bp2");
        chk("bp.full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, ALU_ADD, 32'd3, 32'd0);
        cycle("bp3");
        cycle("bp_hold");
        chk("bp.hold_res", bus.ALUResult, 32'd1);
        bus.out_ready = 1'b1;
        cycle("bp_out1");
        chk("bp.out2", bus.ALUResult, 32'd2);
        cycle("bp_out2");
        chk("bp.out3", bus.ALUResult, 32'd3);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        cycle("bp_out3");
        chk("bp.empty", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  pick(), pick());
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            cycle("rnd");
        end

        // reset while full discards both buffered ops
        bus.out_ready = 1'b0;
        drive(1'b1, ALU_OR, 32'h55, 32'hAA00);
        cycle("rf1");
        cycle("rf2");
        cycle("rf3");
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b0, ALU_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle("post_rst");
        end
        op1("post_rst_op", ALU_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        cycle("final");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
